// File: rtl/loader_pkg.sv
// Shared types and helpers for the ioctl pack loader.
// Optional checksum output is enabled by defining LOADER_CHECKSUM_EN.
package loader_pkg;

  // Data at or above this byte address feeds the running checksum.
  localparam int CHECKSUM_BASE = 'h200;

  // Default geometry, used for the reference packed-word type.
  localparam int DEF_AW    = 25;
  localparam int DEF_OUT_W = 64;

  // Number of IN_W lanes inside one packed word.
  function automatic int lanes(input int out_w, input int in_w);
    return out_w / in_w;
  endfunction

  // Number of byte enables for one packed word.
  function automatic int be_w(input int out_w);
    return out_w / 8;
  endfunction

  // One queued memory write: word address, packed data, byte enables.
  typedef struct packed {
    logic [DEF_AW-1:0]      addr;
    logic [DEF_OUT_W-1:0]   data;
    logic [DEF_OUT_W/8-1:0] be;
  } packed_word_t;

endpackage

// File: rtl/loader_fifo.sv
// Small synchronous FIFO of packed words with occupancy count.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
// i_clear empties the FIFO and wins over push/pop.
module loader_fifo
  import loader_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = packed_word_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_clear,
  input  logic                       i_push,
  input  T                           i_data,
  input  logic                       i_pop,
  output T                           o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  T               r_mem [DEPTH];
  logic [PW-1:0]  r_wr;
  logic [PW-1:0]  r_rd;
  logic [CW-1:0]  r_count;
  logic           w_do_push;
  logic           w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + PW'(1);
      if (w_do_pop)  r_rd <= r_rd + PW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  // Storage array; contents need no reset because occupancy gates reads.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_clear) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/ioctl_pack_loader.sv
// ioctl download stream -> packed wide writes over a toggle handshake.
// Packer accumulates IN_W lanes into one OUT_W word, a FIFO queues words,
// the emitter drives wr_req/wr_ack.
// Handshake: a word is offered when wr_req != wr_ack; wr_addr/wr_data/wr_be
// hold steady until the memory copies wr_req onto wr_ack, which completes it.
// Build option LOADER_CHECKSUM_EN adds the checksum[15:0] output.
module ioctl_pack_loader
  import loader_pkg::*;
#(
  parameter int AW    = 25,
  parameter int IN_W  = 16,
  parameter int OUT_W = 64,
  parameter int DEPTH = 4,
  parameter int SWAP  = 1
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             ioctl_download,
  input  logic             ioctl_wr,
  input  logic [AW-1:0]    ioctl_addr,
  input  logic [IN_W-1:0]  ioctl_dout,
  output logic             ioctl_wait,
  output logic [AW-1:0]    wr_addr,
  output logic [OUT_W-1:0] wr_data,
  output logic [OUT_W/8-1:0] wr_be,
  output logic             wr_req,
  input  logic             wr_ack,
  output logic             busy,
  output logic [AW-1:0]    rom_size,
  output logic             overflow
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [15:0]      checksum
`endif
);

  localparam int LANES  = lanes(OUT_W, IN_W);
  localparam int BE_W   = be_w(OUT_W);
  localparam int IBYTES = IN_W / 8;
  localparam int LSB    = $clog2(IBYTES);
  localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CW     = $clog2(DEPTH + 1);

  if ((IN_W != 8 && IN_W != 16) || (OUT_W % IN_W) != 0 || OUT_W > 128) begin : g_bad_geom
    $error("ioctl_pack_loader: unsupported IN_W/OUT_W combination");
  end

  typedef struct packed {
    logic [AW-1:0]    addr;
    logic [OUT_W-1:0] data;
    logic [BE_W-1:0]  be;
  } word_t;

  // Packer state
  logic             r_dl;
  logic             r_acc_valid;
  logic             r_pend;
  logic [AW-1:0]    r_acc_addr;
  logic [OUT_W-1:0] r_acc_data;
  logic [BE_W-1:0]  r_acc_be;
  logic             r_wait;
  logic             r_overflow;
  logic [AW-1:0]    r_rom_size;
  // Emitter state
  logic             r_wr_req;
  logic [AW-1:0]    r_wr_addr;
  logic [OUT_W-1:0] r_wr_data;
  logic [BE_W-1:0]  r_wr_be;

  logic             w_rise, w_fall, w_wr, w_room, w_accept, w_drop;
  logic             w_hit, w_last, w_push, w_pop, w_full, w_empty;
  logic [LW-1:0]    w_lane;
  logic [AW-1:0]    w_waddr;
  logic [IN_W-1:0]  w_din;
  logic [OUT_W-1:0] w_merge_data;
  logic [BE_W-1:0]  w_merge_be;
  logic [AW:0]      w_end;
  logic [AW-1:0]    w_end_sat;
  logic [CW-1:0]    w_count, w_cnt_next;
  word_t            w_push_word, w_head;
  logic             w_acc_valid_n, w_pend_n;
  logic [AW-1:0]    w_acc_addr_n;
  logic [OUT_W-1:0] w_acc_data_n;
  logic [BE_W-1:0]  w_acc_be_n;

  // A strobe in the very cycle the download opens is ignored: the clear wins.
  assign w_rise   = ioctl_download && !r_dl;
  assign w_fall   = !ioctl_download && r_dl;
  assign w_wr     = ioctl_wr && !w_rise;
  assign w_pop    = !w_empty && (r_wr_req == wr_ack) && !w_rise;
  assign w_room   = !w_full || w_pop;
  assign w_accept = w_wr && w_room;
  assign w_drop   = w_wr && !w_room;

  assign w_lane  = (LANES > 1) ? LW'(ioctl_addr >> LSB) : '0;
  assign w_last  = (w_lane == LW'(LANES - 1));
  assign w_waddr = ioctl_addr & ~AW'(BE_W - 1);
  assign w_hit   = r_acc_valid && (w_waddr == r_acc_addr);

  assign w_end     = {1'b0, ioctl_addr} + (AW+1)'(IBYTES);
  assign w_end_sat = w_end[AW] ? '1 : w_end[AW-1:0];

  // Lane data, byte-swapped for big-endian images.
  always_comb begin
    w_din = ioctl_dout;
    if (SWAP != 0) begin
      for (int b = 0; b < IBYTES; b++) w_din[b*8 +: 8] = ioctl_dout[(IBYTES-1-b)*8 +: 8];
    end
  end

  // Current word with the incoming lane dropped in (fresh word when address differs).
  always_comb begin
    w_merge_data = w_hit ? r_acc_data : '0;
    w_merge_be   = w_hit ? r_acc_be : '0;
    w_merge_data[int'(w_lane)*IN_W +: IN_W] = w_din;
    w_merge_be[int'(w_lane)*IBYTES +: IBYTES] = '1;
  end

  // Packer decision: at most one FIFO push per cycle. A fresh word that must
  // itself be flushed (last lane after an address change, or download end)
  // is marked pending and pushed on the following cycle.
  always_comb begin
    w_push        = 1'b0;
    w_push_word   = '{addr: r_acc_addr, data: r_acc_data, be: r_acc_be};
    w_acc_valid_n = r_acc_valid;
    w_acc_addr_n  = r_acc_addr;
    w_acc_data_n  = r_acc_data;
    w_acc_be_n    = r_acc_be;
    w_pend_n      = r_pend;
    if (w_rise) begin
      w_acc_valid_n = 1'b0;
      w_acc_addr_n  = '0;
      w_acc_data_n  = '0;
      w_acc_be_n    = '0;
      w_pend_n      = 1'b0;
    end else if (w_accept) begin
      if (r_acc_valid && !w_hit) begin
        w_push        = 1'b1;
        w_acc_valid_n = 1'b1;
        w_acc_addr_n  = w_waddr;
        w_acc_data_n  = w_merge_data;
        w_acc_be_n    = w_merge_be;
        w_pend_n      = w_last || w_fall;
      end else if (w_last || r_pend || w_fall) begin
        w_push        = 1'b1;
        w_push_word   = '{addr: w_waddr, data: w_merge_data, be: w_merge_be};
        w_acc_valid_n = 1'b0;
        w_acc_data_n  = '0;
        w_acc_be_n    = '0;
        w_pend_n      = 1'b0;
      end else begin
        w_acc_valid_n = 1'b1;
        w_acc_addr_n  = w_waddr;
        w_acc_data_n  = w_merge_data;
        w_acc_be_n    = w_merge_be;
      end
    end else if (r_acc_valid && (r_pend || w_fall)) begin
      if (w_room) begin
        w_push        = 1'b1;
        w_acc_valid_n = 1'b0;
        w_acc_data_n  = '0;
        w_acc_be_n    = '0;
        w_pend_n      = 1'b0;
      end else begin
        w_pend_n      = 1'b1;
      end
    end
  end

  assign w_cnt_next = w_rise ? '0 : (w_count + CW'(w_push) - CW'(w_pop));

  loader_fifo #(.DEPTH(DEPTH), .T(word_t)) u_fifo (
    .clk     (clk_sys),
    .rst     (reset),
    .i_clear (w_rise),
    .i_push  (w_push),
    .i_data  (w_push_word),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Packer registers, back-pressure, overflow flag and size tracking.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_dl        <= 1'b0;
      r_acc_valid <= 1'b0;
      r_pend      <= 1'b0;
      r_acc_addr  <= '0;
      r_acc_data  <= '0;
      r_acc_be    <= '0;
      r_wait      <= 1'b0;
      r_overflow  <= 1'b0;
      r_rom_size  <= '0;
    end else begin
      r_dl        <= ioctl_download;
      r_acc_valid <= w_acc_valid_n;
      r_pend      <= w_pend_n;
      r_acc_addr  <= w_acc_addr_n;
      r_acc_data  <= w_acc_data_n;
      r_acc_be    <= w_acc_be_n;
      // Fewer than two free slots: a further strobe might need one.
      r_wait      <= (DEPTH - int'(w_cnt_next)) < 2;
      r_overflow  <= w_rise ? 1'b0 : (r_overflow || w_drop);
      if (w_rise)                                 r_rom_size <= '0;
      else if (w_accept && w_end_sat > r_rom_size) r_rom_size <= w_end_sat;
    end
  end

  // Emitter: present the FIFO head and toggle wr_req when the last one is acknowledged.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_wr_req  <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_be   <= '0;
    end else if (w_pop) begin
      r_wr_req  <= ~r_wr_req;
      r_wr_addr <= w_head.addr;
      r_wr_data <= w_head.data;
      r_wr_be   <= w_head.be;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  if (IN_W == 16) begin : g_csum
    logic [15:0] r_checksum;
    // Running sum of big-endian payload words past the header region.
    always_ff @(posedge clk_sys or posedge reset) begin
      if (reset)       r_checksum <= '0;
      else if (w_rise) r_checksum <= '0;
      else if (w_accept && ioctl_addr >= AW'(CHECKSUM_BASE))
        r_checksum <= r_checksum + {ioctl_dout[7:0], ioctl_dout[15:8]};
    end
    assign checksum = r_checksum;
  end else begin : g_csum_bad
    $error("ioctl_pack_loader: checksum needs IN_W == 16");
    assign checksum = '0;
  end
`endif

  assign ioctl_wait = r_wait;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign wr_be      = r_wr_be;
  assign wr_req     = r_wr_req;
  assign rom_size   = r_rom_size;
  assign overflow   = r_overflow;
  assign busy       = r_acc_valid || r_pend || !w_empty || (r_wr_req != wr_ack) || ioctl_download;

endmodule

// File: tb/tb_ioctl_pack_loader.sv
// Directed bench for ioctl_pack_loader (AW=25, IN_W=16, OUT_W=64, DEPTH=4, SWAP=1).
// Define LOADER_CHECKSUM_EN for both bench and RTL to cover the checksum output.
module tb_ioctl_pack_loader;

  localparam int W = 25 + 64 + 8;

  // ---------------- clock / reset ----------------
  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [15:0] ioctl_dout;
  logic        ioctl_wait;
  logic [24:0] wr_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_be;
  logic        wr_req;
  logic        wr_ack;
  logic        busy;
  logic [24:0] rom_size;
  logic        overflow;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  always #5 clk_sys = ~clk_sys;

  ioctl_pack_loader dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_be          (wr_be),
    .wr_req         (wr_req),
    .wr_ack         (wr_ack),
    .busy           (busy),
    .rom_size       (rom_size),
    .overflow       (overflow)
`ifdef LOADER_CHECKSUM_EN
    ,
    .checksum       (checksum)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  bit hold_ack = 1'b0;
  bit saw_wait = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [24:0] a, input logic [63:0] d, input logic [7:0] be);
    return {a, d, be};
  endfunction

  // Memory model: completes each offered word after comparing it to the queue.
  initial begin
    wr_ack = 1'b0;
    forever begin
      @(posedge clk_sys);
      #2;
      if (reset) begin
        wr_ack = 1'b0;
      end else if (!hold_ack && wr_req !== wr_ack) begin
        if (exp_q.size() == 0) check("wr_unexpected_qsize", exp_q.size(), 1);
        else check("wr_word", {wr_addr, wr_data, wr_be}, exp_q.pop_front());
        wr_ack = wr_req;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic ioctl_write(input logic [24:0] a, input logic [15:0] d, input bit force_wr);
    int n = 0;
    if (!force_wr) begin
      while (ioctl_wait && n < 100) begin
        tick(1);
        n++;
      end
      if (n >= 100) check("wait_timeout", n, 0);
    end
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick(1);
    ioctl_wr   = 1'b0;
    if (ioctl_wait) saw_wait = 1'b1;
  endtask

  task automatic dl_start();
    ioctl_download = 1'b1;
    tick(1);
  endtask

  task automatic dl_end();
    ioctl_download = 1'b0;
    tick(1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < 300) begin
      tick(1);
      n++;
    end
    check({tag, "_busy"}, busy, 0);
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] d64;
    logic [15:0] d;
    int n;
    reset = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    tick(3);
    check("rst_wr_req", wr_req, 0);
    check("rst_wait", ioctl_wait, 0);
    check("rst_rom_size", rom_size, 0);
    check("rst_overflow", overflow, 0);
    reset = 1'b0;
    tick(1);
    check("rst_busy", busy, 0);

    // T1: one full word, lane order and byte swap, 2-cycle latency
    exp_q.push_back(mk(25'h0, 64'h8877665544332211, 8'hFF));
    dl_start();
    ioctl_write(25'h0, 16'h1122, 0);
    ioctl_write(25'h2, 16'h3344, 0);
    ioctl_write(25'h4, 16'h5566, 0);
    ioctl_write(25'h6, 16'h7788, 0);
    check("t1_req_lat1", wr_req, 0);
    tick(1);
    check("t1_req_lat2", wr_req, 1);
    check("t1_wr_data", wr_data, 64'h8877665544332211);
    check("t1_rom_size", rom_size, 25'h8);
    dl_end();
    wait_idle("t1");

    // T2: lane rewrite, address change, flush on download end
    exp_q.push_back(mk(25'h0, 64'hCDAB, 8'h03));
    exp_q.push_back(mk(25'h10, 64'h7856, 8'h03));
    dl_start();
    check("t2_rom_clear", rom_size, 0);
    ioctl_write(25'h0, 16'h1234, 0);
    ioctl_write(25'h0, 16'hABCD, 0);
    ioctl_write(25'h10, 16'h5678, 0);
    check("t2_rom_size", rom_size, 25'h12);
    dl_end();
    wait_idle("t2");

    // T3: stall memory, stream 16 words, back-pressure without loss
    hold_ack = 1'b1;
    saw_wait = 1'b0;
    for (int w = 0; w < 4; w++) begin
      d64 = '0;
      for (int j = 0; j < 4; j++) begin
        d = 16'hA000 + 16'((w * 4 + j) * 'h0111);
        d64[j*16 +: 16] = {d[7:0], d[15:8]};
      end
      exp_q.push_back(mk(25'(w * 8), d64, 8'hFF));
    end
    dl_start();
    for (int k = 0; k < 16; k++) ioctl_write(25'(k * 2), 16'hA000 + 16'(k * 'h0111), 0);
    check("t3_wait_high", ioctl_wait, 1);
    check("t3_saw_wait", saw_wait, 1);
    check("t3_overflow", overflow, 0);
    dl_end();
    hold_ack = 1'b0;
    wait_idle("t3");
    check("t3_wait_low", ioctl_wait, 0);

    // T4: ignore wait with a full FIFO; the dropped word never appears
    hold_ack = 1'b1;
    for (int w = 0; w < 5; w++) begin
      d64 = '0;
      for (int j = 0; j < 4; j++) begin
        d = 16'h5000 + 16'(w * 4 + j);
        d64[j*16 +: 16] = {d[7:0], d[15:8]};
      end
      exp_q.push_back(mk(25'(w * 8), d64, 8'hFF));
    end
    dl_start();
    for (int k = 0; k < 20; k++) ioctl_write(25'(k * 2), 16'h5000 + 16'(k), 1);
    check("t4_overflow_pre", overflow, 0);
    ioctl_write(25'h28, 16'hDEAD, 1);
    check("t4_overflow", overflow, 1);
    check("t4_rom_size", rom_size, 25'h28);
    dl_end();
    hold_ack = 1'b0;
    wait_idle("t4");
    check("t4_overflow_sticky", overflow, 1);
    dl_start();
    check("t4_overflow_clr", overflow, 0);
    check("t4_rom_clr", rom_size, 0);
    dl_end();

`ifdef LOADER_CHECKSUM_EN
    // T6: checksum over big-endian words at and above 0x200
    exp_q.push_back(mk(25'h200, 64'h00000000FFFF0201, 8'h0F));
    dl_start();
    check("cs_clear", checksum, 0);
    ioctl_write(25'h200, 16'h0102, 0);
    ioctl_write(25'h202, 16'hFFFF, 0);
    check("cs_value", checksum, 16'h0200);
    dl_end();
    wait_idle("cs");
`endif

    // T5: reset while a request is outstanding
    hold_ack = 1'b1;
    dl_start();
    for (int k = 0; k < 4; k++) ioctl_write(25'h40 + 25'(k * 2), 16'h0F00 + 16'(k), 0);
    dl_end();
    n = 0;
    while (wr_req === wr_ack && n < 50) begin
      tick(1);
      n++;
    end
    check("t5_req_pending", wr_req ^ wr_ack, 1);
    check("t5_addr_pre", wr_addr, 25'h40);
    reset = 1'b1;
    #3;
    check("t5_rst_req", wr_req, 0);
    check("t5_rst_addr", wr_addr, 0);
    check("t5_rst_data", wr_data, 0);
    check("t5_rst_be", wr_be, 0);
    check("t5_rst_wait", ioctl_wait, 0);
    check("t5_rst_rom", rom_size, 0);
    check("t5_rst_ovf", overflow, 0);
    tick(1);
    reset = 1'b0;
    hold_ack = 1'b0;
    tick(1);
    check("t5_busy_after", busy, 0);
    check("t5_req_after", wr_req, 0);
    tick(3);
    check("t5_no_extra", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
